// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the SRAM BIST controller.
package sram_bist_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 10;

  localparam logic [DEF_DATA_W-1:0] BG0 = 10'h000;
  localparam logic [DEF_DATA_W-1:0] BG1 = 10'h3FF;

  typedef enum logic [2:0] {
    IDLE,
    W_ALL,
    RD_ADDR,
    RD_WAIT,
    RD_CMP,
    DONE
  } state_e;

  localparam logic [2:0] E0 = 3'd0;
  localparam logic [2:0] E1 = 3'd1;
  localparam logic [2:0] E2 = 3'd2;
  localparam logic [2:0] E3 = 3'd3;
  localparam logic [2:0] E4 = 3'd4;
  localparam logic [2:0] E5 = 3'd5;

  // Per-element tables, bit index = element number; 1 = down / all-ones background
  localparam logic [5:0] ELEM_DOWN   = 6'b01_1000;
  localparam logic [5:0] ELEM_RD_BG  = 6'b01_0100;
  localparam logic [5:0] ELEM_WR_BG  = 6'b00_1010;
  localparam logic [5:0] ELEM_HAS_WR = 6'b01_1111;

endpackage

// File: rtl/sram_bist_if.sv
// SRAM port bundle between the BIST controller (master) and the SRAM (slave).
interface sram_bist_if
  import sram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic              o_ena;
  logic              o_wea;
  logic [ADDR_W-1:0] o_addra;
  logic [DATA_W-1:0] o_dina;
  logic [DATA_W-1:0] i_douta;

  modport master (output o_ena, o_wea, o_addra, o_dina, input i_douta);
  modport slave  (input o_ena, o_wea, o_addra, o_dina, output i_douta);
endinterface

// File: rtl/sram_bist_addr_gen.sv
// Loadable up/down address counter; direction is captured on load.
module sram_bist_addr_gen #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              step,
  input  logic              dir,
  input  logic              load,
  output logic [ADDR_W-1:0] addr,
  output logic              last_c
);
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH - 1);

  logic dir_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      addr  <= '0;
      dir_q <= 1'b0;
    end else if (load) begin
      addr  <= dir ? MAX_ADDR : '0;
      dir_q <= dir;
    end else if (step) begin
      addr  <= dir_q ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
    end
  end

  assign last_c = dir_q ? (addr == '0) : (addr == MAX_ADDR);
endmodule

// File: rtl/sram_bist_ctrl.sv
// March C- BIST controller for a 256x10 single-port SRAM.
// Optional SRAM_BIST_FAIL_CNT_EN: run to completion and count every mismatch.
module sram_bist_ctrl
  import sram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_fail,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic [2:0]        o_fail_elem,
`ifdef SRAM_BIST_FAIL_CNT_EN
  output logic [ADDR_W+3:0] o_fail_cnt,
`endif
  sram_bist_if.master       sram
);
`ifdef SRAM_BIST_FAIL_CNT_EN
  localparam bit FAIL_CNT_EN = 1'b1;
  localparam int unsigned CNT_W = ADDR_W + 4;
`else
  localparam bit FAIL_CNT_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic              ag_step, ag_load, ag_dir, ag_last_c;
  logic [ADDR_W-1:0] cnt;
  logic              start_ok, mismatch, wr_en;
  logic [DATA_W-1:0] rd_bg, wr_bg;
  logic              ena_c, wea_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] dina_c;

  sram_bist_addr_gen #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_addr_gen (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .step   (ag_step),
    .dir    (ag_dir),
    .load   (ag_load),
    .addr   (cnt),
    .last_c (ag_last_c)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      elem_q  <= E0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
    end
  end

  // Next state and SRAM port decode
  always_comb begin
    state_d  = state_q;
    elem_d   = elem_q;
    ag_step  = 1'b0;
    ag_load  = 1'b0;
    ag_dir   = 1'b0;
    start_ok = 1'b0;
    mismatch = 1'b0;
    wr_en    = 1'b0;
    ena_c    = 1'b0;
    wea_c    = 1'b0;
    addr_c   = '0;
    dina_c   = '0;
    rd_bg    = {DATA_W{ELEM_RD_BG[elem_q]}};
    wr_bg    = {DATA_W{ELEM_WR_BG[elem_q]}};
    unique case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          start_ok = 1'b1;
          elem_d   = E0;
          ag_load  = 1'b1;
          ag_dir   = ELEM_DOWN[E0];
          state_d  = W_ALL;
        end
      end
      W_ALL: begin
        ena_c   = 1'b1;
        wea_c   = 1'b1;
        addr_c  = cnt;
        dina_c  = wr_bg;
        ag_step = 1'b1;
        if (ag_last_c) begin
          elem_d  = E1;
          ag_load = 1'b1;
          ag_dir  = ELEM_DOWN[E1];
          state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        ena_c   = 1'b1;
        addr_c  = cnt;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        ena_c   = 1'b1;
        addr_c  = cnt;
        state_d = RD_CMP;
      end
      RD_CMP: begin
        mismatch = (sram.i_douta != rd_bg);
        wr_en    = ELEM_HAS_WR[elem_q] && (FAIL_CNT_EN || !mismatch);
        ena_c    = wr_en;
        wea_c    = wr_en;
        addr_c   = cnt;
        dina_c   = wr_bg;
        if (mismatch && !FAIL_CNT_EN) begin
          state_d = DONE;
        end else if (ag_last_c) begin
          if (elem_q == E5) begin
            state_d = DONE;
          end else begin
            elem_d  = elem_q + 3'd1;
            ag_load = 1'b1;
            ag_dir  = ELEM_DOWN[elem_d];
            state_d = RD_ADDR;
          end
        end else begin
          ag_step = 1'b1;
          state_d = RD_ADDR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sram.o_ena   = ena_c;
  assign sram.o_wea   = wea_c;
  assign sram.o_addra = addr_c;
  assign sram.o_dina  = dina_c;

  // Status flags and first-fail record
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_fail      <= 1'b0;
      o_fail_addr <= '0;
      o_fail_elem <= '0;
    end else begin
      o_busy <= (state_d == W_ALL) || (state_d == RD_ADDR) ||
                (state_d == RD_WAIT) || (state_d == RD_CMP);
      o_done <= (state_d == DONE);
      if (start_ok) begin
        o_fail      <= 1'b0;
        o_fail_addr <= '0;
        o_fail_elem <= '0;
      end else if (mismatch && !o_fail) begin
        o_fail      <= 1'b1;
        o_fail_addr <= cnt;
        o_fail_elem <= elem_q;
      end
    end
  end

`ifdef SRAM_BIST_FAIL_CNT_EN
  // Saturating mismatch counter
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_fail_cnt <= '0;
    end else if (start_ok) begin
      o_fail_cnt <= '0;
    end else if (mismatch && (o_fail_cnt != '1)) begin
      o_fail_cnt <= o_fail_cnt + CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Bench for sram_bist_ctrl: faulty-SRAM model plus a march-level reference.
module tb_sram_bist_ctrl;
`ifdef SRAM_BIST_FAIL_CNT_EN
  localparam bit CNT_EN = 1'b1;
  logic [11:0] fail_cnt;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       busy, done, fail;
  logic [7:0] fail_addr;
  logic [2:0] fail_elem;

  int tests = 0;
  int fails = 0;

  logic [9:0] sa1 [256];
  logic [9:0] sa0 [256];
  logic [9:0] mem [256];
  logic [7:0] areg;
  logic [9:0] douta;
  logic [7:0] last_wa;
  logic [9:0] last_wd;

  sram_bist_if bus ();

  sram_bist_ctrl dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_start     (start),
    .o_busy      (busy),
    .o_done      (done),
    .o_fail      (fail),
    .o_fail_addr (fail_addr),
    .o_fail_elem (fail_elem),
`ifdef SRAM_BIST_FAIL_CNT_EN
    .o_fail_cnt  (fail_cnt),
`endif
    .sram        (bus)
  );

  always #5 clk = ~clk;

  // SRAM with stuck-at faults applied on the read path
  always @(posedge clk) begin
    if (bus.o_ena) begin
      if (bus.o_wea) begin
        mem[bus.o_addra] <= bus.o_dina;
        last_wa <= bus.o_addra;
        last_wd <= bus.o_dina;
      end else begin
        douta <= (mem[areg] | sa1[areg]) & ~sa0[areg];
      end
      areg <= bus.o_addra;
    end
  end
  assign bus.i_douta = douta;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_stat"}, 32'({busy, done, fail, fail_addr, fail_elem}), 32'd0);
    check({tag, "_bus"}, 32'({bus.o_ena, bus.o_wea, bus.o_addra, bus.o_dina}), 32'd0);
`ifdef SRAM_BIST_FAIL_CNT_EN
    check({tag, "_cnt"}, 32'(fail_cnt), 32'd0);
`endif
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 256; i++) begin
      sa1[i] = '0;
      sa0[i] = '0;
    end
  endtask

  // March C- walked word by word on a plain array; cycles = 1 per write-only, 3 per read step
  function automatic void model(output logic [31:0] fl, output logic [31:0] fa,
                                output logic [31:0] fe, output logic [31:0] cyc,
                                output logic [31:0] cnt, output logic [31:0] wa,
                                output logic [31:0] wd);
    logic [9:0] m [256];
    logic [9:0] rd, rbg, wbg;
    int a;
    bit down, stop;
    fl = 0; fa = 0; fe = 0; cyc = 0; cnt = 0; wa = 0; wd = 0; stop = 0;
    for (int e = 0; e < 6 && !stop; e++) begin
      down = (e == 3) || (e == 4);
      rbg  = (e == 2 || e == 4) ? 10'h3FF : 10'h000;
      wbg  = (e == 1 || e == 3) ? 10'h3FF : 10'h000;
      for (int k = 0; k < 256 && !stop; k++) begin
        a = down ? 255 - k : k;
        if (e == 0) begin
          m[a] = wbg; cyc++; wa = a; wd = 32'(wbg);
          continue;
        end
        cyc += 3;
        rd = (m[a] | sa1[a]) & ~sa0[a];
        if (rd != rbg) begin
          if (cnt < 4095) cnt++;
          if (fl == 0) begin fl = 1; fa = a; fe = e; end
          if (!CNT_EN) begin stop = 1; continue; end
        end
        if (e <= 4) begin m[a] = wbg; wa = a; wd = 32'(wbg); end
      end
    end
  endfunction

  // Pulse start, then count busy cycles until done (optional extra start / mid-run reset)
  task automatic run_march(input int s2, input int rst_at, output int busy_n,
                           output logic [1:0] df);
    int n;
    bit fin;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    df = {done, fail};
    busy_n = 0; n = 0; fin = 0;
    while (!fin) begin
      if (busy === 1'b1) busy_n++;
      n++;
      if (done === 1'b1) begin
        fin = 1;
      end else if (n == rst_at) begin
        #2 rstn = 1'b0;
        #1 check_reset("rst_mid");
        fin = 1;
      end else if (n > 6000) begin
        check("timeout", 32'(n), 32'd4097);
        fin = 1;
      end else begin
        start = (n == s2);
        @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string tag, input int s2, output int busy_n);
    logic [31:0] e_fl, e_fa, e_fe, e_cyc, e_cnt, e_wa, e_wd;
    logic [1:0] df;
    model(e_fl, e_fa, e_fe, e_cyc, e_cnt, e_wa, e_wd);
    run_march(s2, 0, busy_n, df);
    check({tag, "_clr"}, 32'(df), 32'd0);
    check({tag, "_cycles"}, 32'(busy_n), e_cyc);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_fail"}, 32'(fail), e_fl);
    if (e_fl != 0) begin
      check({tag, "_faddr"}, 32'(fail_addr), e_fa);
      check({tag, "_felem"}, 32'(fail_elem), e_fe);
    end
    check({tag, "_last_w"}, 32'({last_wa, last_wd}), (e_wa << 10) | e_wd);
`ifdef SRAM_BIST_FAIL_CNT_EN
    check({tag, "_cnt"}, 32'(fail_cnt), e_cnt);
`endif
  endtask

  initial begin
    int n;
    logic [1:0] df;
    int a, b;
    rstn  = 1'b0;
    start = 1'b0;
    clear_faults();
    repeat (3) @(negedge clk);
    check_reset("rst_init");
    rstn = 1'b1;
    @(negedge clk);

    check_run("ff", 0, n);
    check("ff_4096", 32'(n), 32'd4096);
    check("ff_last_zero", 32'({last_wa, last_wd}), 32'd0);

    check_run("start_busy", 500, n);
    check("start_busy_4096", 32'(n), 32'd4096);

    sa1[8'h5A][3] = 1'b1;
    check_run("sa1_5a", 0, n);
    check("sa1_5a_addr", 32'(fail_addr), 32'h5A);
    check("sa1_5a_elem", 32'(fail_elem), 32'd1);
    if (!CNT_EN) check("sa1_5a_lat", 32'(n), 32'(256 + 8'h5A * 3 + 3));
    check_run("sa1_5a_again", 0, n);

    clear_faults();
    sa0[8'hFF][0] = 1'b1;
    check_run("sa0_ff", 0, n);
    check("sa0_ff_addr", 32'(fail_addr), 32'hFF);
    check("sa0_ff_elem", 32'(fail_elem), 32'd2);

    clear_faults();
    run_march(0, 1000, n, df);
    @(negedge clk);
    check_reset("rst_hold");
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_idle", 32'({busy, done, bus.o_ena}), 32'd0);
    check_run("after_rst", 0, n);
    check("after_rst_4096", 32'(n), 32'd4096);

    for (int r = 0; r < 4; r++) begin
      clear_faults();
      for (int f = 0; f < 2; f++) begin
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 9));
        if ($urandom_range(0, 1) == 1) sa1[a][b] = 1'b1;
        else sa0[a][b] = 1'b1;
      end
      check_run($sformatf("rand%0d", r), 0, n);
    end

`ifdef SRAM_BIST_FAIL_CNT_EN
    clear_faults();
    sa1[8'h10][0] = 1'b1;
    sa1[8'h20][5] = 1'b1;
    check_run("cnt2", 0, n);
    check("cnt2_4096", 32'(n), 32'd4096);
    check("cnt2_six", 32'(fail_cnt), 32'd6);
    check("cnt2_addr", 32'(fail_addr), 32'h10);
    check("cnt2_elem", 32'(fail_elem), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
